ddr2_cmd_responder: RTL and testbench

Memory-side command decoder and protocol checker for the DDR2 command bus driven by ddr2_top. It samples cke/cs_n/ras_n/cas_n/we_n/ba/addr on the rising edge of ck and decodes each command. It tracks the initialisation sequence, captures the mode registers and tracks per-bank open rows. It enforces tRCD, tRP, tRFC and tMRD, and raises sticky error flags. It sits beside the ddr2 model in simulation and can be synthesised as an on-chip bus monitor.

---
 rtl/ddr2_cmd_pkg.sv | 65 ++++++
 rtl/ddr2_bank_tracker.sv | 68 ++++++
 rtl/ddr2_cmd_responder.sv | 158 +++++++++++++++
 tb/tb_ddr2_cmd_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_cmd_pkg.sv
// Shared command codes, init-sequence states and error-bit positions for the
// DDR2 command-bus responder.
package ddr2_cmd_pkg;

  localparam logic [3:0] NOP     = 4'd0;
  localparam logic [3:0] DESEL   = 4'd1;
  localparam logic [3:0] ACT     = 4'd2;
  localparam logic [3:0] RD      = 4'd3;
  localparam logic [3:0] WR      = 4'd4;
  localparam logic [3:0] PRE     = 4'd5;
  localparam logic [3:0] PREA    = 4'd6;
  localparam logic [3:0] REF     = 4'd7;
  localparam logic [3:0] MRS     = 4'd8;
  localparam logic [3:0] ILLEGAL = 4'd9;

  typedef enum logic [3:0] {
    W_PREA  = 4'd0,
    W_EMR2  = 4'd1,
    W_EMR3  = 4'd2,
    W_EMR1  = 4'd3,
    W_MRDLL = 4'd4,
    W_PREA2 = 4'd5,
    W_REF1  = 4'd6,
    W_REF2  = 4'd7,
    W_MR    = 4'd8,
    READY   = 4'd9
  } init_state_t;

  localparam int ERR_TRCD    = 0;
  localparam int ERR_TRP     = 1;
  localparam int ERR_TRFC    = 2;
  localparam int ERR_TMRD    = 3;
  localparam int ERR_STATE   = 4;
  localparam int ERR_INIT    = 5;
  localparam int ERR_ILLEGAL = 6;
  localparam int ERR_W       = 7;

  // cke low is folded into DESEL: power-down is not modelled.
  function automatic logic [3:0] decode_cmd(
    input logic cke_i,
    input logic cs_n_i,
    input logic ras_n_i,
    input logic cas_n_i,
    input logic we_n_i,
    input logic a10
  );
    logic [3:0] c;
    if (!cke_i || cs_n_i) begin
      c = DESEL;
    end else begin
      case ({ras_n_i, cas_n_i, we_n_i})
        3'b011:  c = ACT;
        3'b101:  c = RD;
        3'b100:  c = WR;
        3'b010:  c = a10 ? PREA : PRE;
        3'b001:  c = REF;
        3'b000:  c = MRS;
        3'b111:  c = NOP;
        default: c = ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr2_bank_tracker.sv
// Per-bank open/row state with tRCD and tRP countdowns; flags bank-level
// protocol violations as single-cycle pulses for the top to accumulate.
module ddr2_bank_tracker
  import ddr2_cmd_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int TRCD      = 3,
  parameter int TRP       = 3
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic [3:0]           cmd,
  input  logic                 hit,
  input  logic                 ap,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 open,
  output logic [ADDR_BITS-1:0] row,
  output logic                 err_trcd,
  output logic                 err_trp,
  output logic                 err_state
);

  localparam int RCD_W = $clog2(TRCD + 1);
  localparam int RP_W  = $clog2(TRP + 1);

  logic [RCD_W-1:0] trcd_cnt;
  logic [RP_W-1:0]  trp_cnt;
  logic             act;
  logic             rw;
  logic             pre;
  logic             ref_mrs;

  always_comb begin
    act     = hit && (cmd == ACT);
    rw      = hit && ((cmd == RD) || (cmd == WR));
    pre     = (hit && (cmd == PRE)) || (cmd == PREA);
    ref_mrs = (cmd == REF) || (cmd == MRS);
  end

  // A counter loaded with T-1 at edge n reaches zero exactly at edge n+T.
  assign err_trcd  = rw && (trcd_cnt != '0);
  assign err_trp   = act && (trp_cnt != '0);
  assign err_state = (act && open) || (rw && !open) || (ref_mrs && open);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      open     <= 1'b0;
      row      <= '0;
      trcd_cnt <= '0;
      trp_cnt  <= '0;
    end else begin
      if (act) begin
        open     <= 1'b1;
        row      <= addr;
        trcd_cnt <= RCD_W'(TRCD - 1);
      end else if (trcd_cnt != '0) begin
        trcd_cnt <= trcd_cnt - 1'b1;
      end
      if (pre || (rw && ap)) begin
        open    <= 1'b0;
        trp_cnt <= RP_W'(TRP - 1);
      end else if (trp_cnt != '0) begin
        trp_cnt <= trp_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2_cmd_responder.sv
// DDR2 command-bus decoder and protocol checker: follows the init sequence,
// captures mode registers, tracks open rows and raises sticky timing/state errors.
module ddr2_cmd_responder
  import ddr2_cmd_pkg::*;
#(
  parameter int  BA_BITS   = 2,
  parameter int  ADDR_BITS = 13,
  parameter int  TRCD      = 3,
  parameter int  TRP       = 3,
  parameter int  TRFC      = 26,
  parameter int  TMRD      = 2,
  localparam int NUM_BANKS = 2 ** BA_BITS
) (
  input  logic                           ck,
  input  logic                           rst_n,
  input  logic                           cke,
  input  logic                           cs_n,
  input  logic                           ras_n,
  input  logic                           cas_n,
  input  logic                           we_n,
  input  logic [BA_BITS-1:0]             ba,
  input  logic [ADDR_BITS-1:0]           addr,
  input  logic                           err_clr,
  output logic [3:0]                     cmd,
  output logic                           cmd_vld,
  output logic                           init_done,
  output logic [ADDR_BITS-1:0]           mr0,
  output logic [ADDR_BITS-1:0]           emr1,
  output logic [ADDR_BITS-1:0]           emr2,
  output logic [ADDR_BITS-1:0]           emr3,
  output logic [NUM_BANKS-1:0]           bank_open,
  output logic [NUM_BANKS*ADDR_BITS-1:0] open_rows,
  output logic [ERR_W-1:0]               err
);

  localparam int RFC_W = $clog2(TRFC + 1);
  localparam int MRD_W = $clog2(TMRD + 1);

  logic [3:0]           dec;
  logic                 valid;
  logic [1:0]           mrs_sel;
  logic                 exp_ok;
  logic [ERR_W-1:0]     viol;
  logic [NUM_BANKS-1:0] trcd_e;
  logic [NUM_BANKS-1:0] trp_e;
  logic [NUM_BANKS-1:0] state_e;
  logic [RFC_W-1:0]     rfc_cnt;
  logic [MRD_W-1:0]     mrd_cnt;
  init_state_t          state;

  assign dec     = decode_cmd(cke, cs_n, ras_n, cas_n, we_n, addr[10]);
  assign valid   = (dec != NOP) && (dec != DESEL);
  assign mrs_sel = 2'(ba);

  always_comb begin
    exp_ok = 1'b0;
    case (state)
      W_PREA, W_PREA2: exp_ok = (dec == PREA);
      W_EMR2:          exp_ok = (dec == MRS) && (mrs_sel == 2'd2);
      W_EMR3:          exp_ok = (dec == MRS) && (mrs_sel == 2'd3);
      W_EMR1:          exp_ok = (dec == MRS) && (mrs_sel == 2'd1);
      W_MRDLL:         exp_ok = (dec == MRS) && (mrs_sel == 2'd0) && addr[8];
      W_REF1, W_REF2:  exp_ok = (dec == REF);
      W_MR:            exp_ok = (dec == MRS) && (mrs_sel == 2'd0);
      default:         exp_ok = 1'b0;
    endcase
  end

  always_comb begin
    viol              = '0;
    viol[ERR_TRCD]    = |trcd_e;
    viol[ERR_TRP]     = |trp_e;
    viol[ERR_TRFC]    = valid && (rfc_cnt != '0);
    viol[ERR_TMRD]    = valid && (mrd_cnt != '0);
    viol[ERR_STATE]   = |state_e;
    viol[ERR_INIT]    = valid && (state != READY) && !exp_ok;
    viol[ERR_ILLEGAL] = (dec == ILLEGAL);
  end

  // Any out-of-order command restarts the sequence from the first PREA.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= W_PREA;
      init_done <= 1'b0;
    end else if (valid && (state != READY)) begin
      if (exp_ok) begin
        state     <= init_state_t'(state + 4'd1);
        init_done <= (state == W_MR);
      end else begin
        state <= W_PREA;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rfc_cnt <= '0;
      mrd_cnt <= '0;
    end else begin
      if (dec == REF) begin
        rfc_cnt <= RFC_W'(TRFC - 1);
      end else if (rfc_cnt != '0) begin
        rfc_cnt <= rfc_cnt - 1'b1;
      end
      if (dec == MRS) begin
        mrd_cnt <= MRD_W'(TMRD - 1);
      end else if (mrd_cnt != '0) begin
        mrd_cnt <= mrd_cnt - 1'b1;
      end
    end
  end

  // A violation seen on the clear edge survives the clear.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= NOP;
      cmd_vld <= 1'b0;
      mr0     <= '0;
      emr1    <= '0;
      emr2    <= '0;
      emr3    <= '0;
      err     <= '0;
    end else begin
      cmd     <= dec;
      cmd_vld <= valid;
      err     <= (err_clr ? '0 : err) | viol;
      if (dec == MRS) begin
        case (mrs_sel)
          2'd0:    mr0  <= addr;
          2'd1:    emr1 <= addr;
          2'd2:    emr2 <= addr;
          default: emr3 <= addr;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    ddr2_bank_tracker #(
      .ADDR_BITS(ADDR_BITS),
      .TRCD     (TRCD),
      .TRP      (TRP)
    ) u_bank (
      .ck       (ck),
      .rst_n    (rst_n),
      .cmd      (dec),
      .hit      (ba == BA_BITS'(i)),
      .ap       (addr[10]),
      .addr     (addr),
      .open     (bank_open[i]),
      .row      (open_rows[i*ADDR_BITS +: ADDR_BITS]),
      .err_trcd (trcd_e[i]),
      .err_trp  (trp_e[i]),
      .err_state(state_e[i])
    );
  end

endmodule

// File: tb/tb_ddr2_cmd_responder.sv
// Bench for ddr2_cmd_responder: directed scenarios plus random command traffic,
// checked every cycle against a timestamp-based behavioural model.
module tb_ddr2_cmd_responder;
  import ddr2_cmd_pkg::*;

  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TRFC = 26;
  localparam int TMRD = 2;
  localparam int NB   = 4;

  localparam logic [2:0] R_ACT = 3'b011;
  localparam logic [2:0] R_RD  = 3'b101;
  localparam logic [2:0] R_WR  = 3'b100;
  localparam logic [2:0] R_PRE = 3'b010;
  localparam logic [2:0] R_REF = 3'b001;
  localparam logic [2:0] R_MRS = 3'b000;
  localparam logic [2:0] R_ILL = 3'b110;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b0;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [1:0]  ba = '0;
  logic [12:0] addr = '0;
  logic        err_clr = 1'b0;
  logic [3:0]  cmd;
  logic        cmd_vld;
  logic        init_done;
  logic [12:0] mr0, emr1, emr2, emr3;
  logic [3:0]  bank_open;
  logic [51:0] open_rows;
  logic [6:0]  err;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  ddr2_cmd_responder #(
    .BA_BITS(2), .ADDR_BITS(13), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TMRD(TMRD)
  ) dut (
    .ck(ck), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .err_clr(err_clr), .cmd(cmd), .cmd_vld(cmd_vld),
    .init_done(init_done), .mr0(mr0), .emr1(emr1), .emr2(emr2), .emr3(emr3),
    .bank_open(bank_open), .open_rows(open_rows), .err(err)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // ---------------- behavioural model: edge timestamps and flags ----------------
  int          now;
  int          act_t[NB];
  int          pre_t[NB];
  int          ref_t;
  int          mrs_t;
  bit          m_open[NB];
  logic [12:0] m_row[NB];
  logic [12:0] m_mr[4];
  int          m_step;
  logic [6:0]  m_err;
  logic [3:0]  m_cmd;
  bit          m_vld;

  task automatic model_reset();
    now = 0;
    ref_t = -1000;
    mrs_t = -1000;
    for (int i = 0; i < NB; i++) begin
      act_t[i] = -1000;
      pre_t[i] = -1000;
      m_open[i] = 0;
      m_row[i] = '0;
      m_mr[i] = '0;
    end
    m_step = 0;
    m_err = '0;
    m_cmd = NOP;
    m_vld = 0;
  endtask

  function automatic bit init_ok(input int step, input logic [3:0] c, input int b, input logic a8);
    case (step)
      0, 5:    return c == PREA;
      1:       return (c == MRS) && (b == 2);
      2:       return (c == MRS) && (b == 3);
      3:       return (c == MRS) && (b == 1);
      4:       return (c == MRS) && (b == 0) && a8;
      6, 7:    return c == REF;
      8:       return (c == MRS) && (b == 0);
      default: return 0;
    endcase
  endfunction

  initial begin : model
    logic [3:0] c;
    logic [6:0] v;
    bit         valid;
    bit         any_open;
    int         b;
    model_reset();
    forever begin
      @(posedge ck or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        now++;
        b = int'(ba);
        if (!cke || cs_n) c = DESEL;
        else if ({ras_n, cas_n, we_n} == R_ACT) c = ACT;
        else if ({ras_n, cas_n, we_n} == R_RD) c = RD;
        else if ({ras_n, cas_n, we_n} == R_WR) c = WR;
        else if ({ras_n, cas_n, we_n} == R_PRE) c = addr[10] ? PREA : PRE;
        else if ({ras_n, cas_n, we_n} == R_REF) c = REF;
        else if ({ras_n, cas_n, we_n} == R_MRS) c = MRS;
        else if ({ras_n, cas_n, we_n} == R_ILL) c = ILLEGAL;
        else c = NOP;
        valid = (c != NOP) && (c != DESEL);
        v = '0;
        if (valid && (now - ref_t < TRFC)) v[2] = 1;
        if (valid && (now - mrs_t < TMRD)) v[3] = 1;
        if (c == ILLEGAL) v[6] = 1;
        if (valid && m_step < 9) begin
          if (init_ok(m_step, c, b, addr[8])) m_step++;
          else begin
            v[5] = 1;
            m_step = 0;
          end
        end
        any_open = 0;
        for (int i = 0; i < NB; i++) any_open |= m_open[i];
        case (c)
          ACT: begin
            if (m_open[b]) v[4] = 1;
            if (now - pre_t[b] < TRP) v[1] = 1;
            m_open[b] = 1;
            m_row[b] = addr;
            act_t[b] = now;
          end
          RD, WR: begin
            if (!m_open[b]) v[4] = 1;
            if (now - act_t[b] < TRCD) v[0] = 1;
            if (addr[10]) begin
              m_open[b] = 0;
              pre_t[b] = now;
            end
          end
          PRE: begin
            m_open[b] = 0;
            pre_t[b] = now;
          end
          PREA: begin
            for (int i = 0; i < NB; i++) begin
              m_open[i] = 0;
              pre_t[i] = now;
            end
          end
          REF: begin
            if (any_open) v[4] = 1;
            ref_t = now;
          end
          MRS: begin
            if (any_open) v[4] = 1;
            mrs_t = now;
            m_mr[b] = addr;
          end
          default: ;
        endcase
        m_err = (err_clr ? 7'd0 : m_err) | v;
        m_cmd = c;
        m_vld = valid;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  initial begin : compare
    logic [3:0] exp_open;
    forever begin
      @(negedge ck);
      if (chk_en) begin
        for (int i = 0; i < NB; i++) exp_open[i] = m_open[i];
        chk("cmd", 64'(cmd), 64'(m_cmd));
        chk("cmd_vld", 64'(cmd_vld), 64'(m_vld));
        chk("init_done", 64'(init_done), 64'(m_step == 9));
        chk("mr0", 64'(mr0), 64'(m_mr[0]));
        chk("emr1", 64'(emr1), 64'(m_mr[1]));
        chk("emr2", 64'(emr2), 64'(m_mr[2]));
        chk("emr3", 64'(emr3), 64'(m_mr[3]));
        chk("bank_open", 64'(bank_open), 64'(exp_open));
        chk("open_rows", 64'(open_rows), 64'({m_row[3], m_row[2], m_row[1], m_row[0]}));
        chk("err", 64'(err), 64'(m_err));
      end
    end
  end

  // ---------------- stimulus (called at a falling edge) ----------------
  task automatic drv(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] a);
    cke = 1'b1;
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = rcw;
    ba = b;
    addr = a;
    @(negedge ck);
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = 3'b111;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(negedge ck);
    err_clr = 1'b0;
  endtask

  task automatic run_init();
    drv(R_PRE, 2'd0, 13'h400);
    drv(R_MRS, 2'd2, 13'h000);
    idle(1);
    drv(R_MRS, 2'd3, 13'h000);
    idle(1);
    drv(R_MRS, 2'd1, 13'h004);
    idle(1);
    drv(R_MRS, 2'd0, 13'h100);
    idle(1);
    drv(R_PRE, 2'd0, 13'h400);
    drv(R_REF, 2'd0, 13'h000);
    idle(25);
    drv(R_REF, 2'd0, 13'h000);
    idle(25);
    drv(R_MRS, 2'd0, 13'h042);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         r;
    logic [1:0] b;
    logic [12:0] a;
    logic [2:0] rtab[8];
    rtab = '{R_ACT, R_RD, R_WR, R_PRE, R_REF, R_MRS, 3'b111, R_ILL};

    repeat (2) @(negedge ck);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
    rst_n = 1'b1;
    chk_en = 1;

    // legal init sequence
    run_init();
    chk("t1_init_done", 64'(init_done), 64'd1);
    chk("t1_mr0", 64'(mr0), 64'h042);
    chk("t1_emr1", 64'(emr1), 64'h004);
    chk("t1_err", 64'(err), 64'd0);

    // tRCD: RD at n+3 legal, then at n+2 violating
    idle(1);
    drv(R_ACT, 2'd1, 13'h1A5);
    idle(2);
    drv(R_RD, 2'd1, 13'h000);
    chk("t2_bank_open", 64'(bank_open), 64'b0010);
    chk("t2_row1", 64'(open_rows[25:13]), 64'h1A5);
    chk("t2_err", 64'(err), 64'd0);
    drv(R_PRE, 2'd1, 13'h000);
    idle(2);
    drv(R_ACT, 2'd1, 13'h0AA);
    idle(1);
    drv(R_RD, 2'd1, 13'h000);
    chk("t2_trcd", 64'(err), 64'h01);

    // tRP: ACT at n+2 violating, after clear ACT at n+3 legal
    clr();
    chk("t3_clr", 64'(err), 64'd0);
    drv(R_ACT, 2'd0, 13'h005);
    idle(2);
    drv(R_PRE, 2'd0, 13'h000);
    idle(1);
    drv(R_ACT, 2'd0, 13'h006);
    chk("t3_trp", 64'(err), 64'h02);
    clr();
    drv(R_PRE, 2'd0, 13'h000);
    idle(2);
    drv(R_ACT, 2'd0, 13'h007);
    chk("t3_legal", 64'(err), 64'd0);

    // tRFC: ACT at n+25 violating; REF with banks open
    drv(R_PRE, 2'd0, 13'h400);
    drv(R_REF, 2'd0, 13'h000);
    idle(24);
    drv(R_ACT, 2'd0, 13'h008);
    chk("t4_trfc", 64'(err), 64'h04);
    clr();
    drv(R_ACT, 2'd2, 13'h009);
    idle(2);
    drv(R_REF, 2'd0, 13'h000);
    chk("t4_state", 64'(err), 64'h10);
    chk("t4_bank_open", 64'(bank_open), 64'b0101);

    // asynchronous reset mid-burst
    #3 rst_n = 1'b0;
    #1;
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_bank_open", 64'(bank_open), 64'd0);
    chk("t6_open_rows", 64'(open_rows), 64'd0);
    chk("t6_init_done", 64'(init_done), 64'd0);
    chk("t6_cmd", 64'({cmd_vld, cmd}), 64'd0);
    chk("t6_mr", 64'({mr0, emr1, emr2}), 64'd0);
    @(negedge ck);
    rst_n = 1'b1;

    // out-of-order init and ILLEGAL
    drv(R_REF, 2'd0, 13'h000);
    chk("t5_init_err", 64'(err), 64'h20);
    chk("t5_init_done", 64'(init_done), 64'd0);
    idle(26);
    drv(R_ILL, 2'd0, 13'h000);
    chk("t5_ill_cmd", 64'(cmd), 64'(ILLEGAL));
    chk("t5_ill_err", 64'(err), 64'h60);
    idle(1);
    run_init();
    chk("t5_reinit", 64'(init_done), 64'd1);

    // random traffic; a reset half-way exercises the init checker too
    for (int i = 0; i < 2500; i++) begin
      if (i == 1250) begin
        rst_n = 1'b0;
        @(negedge ck);
        rst_n = 1'b1;
      end
      b = 2'($urandom);
      a = 13'($urandom);
      err_clr = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 15);
      if (r <= 5) begin
        @(negedge ck);
      end else if (r <= 7) begin
        drv(R_ACT, b, a);
      end else if (r == 8) begin
        drv(R_RD, b, a);
      end else if (r == 9) begin
        drv(R_WR, b, a);
      end else if (r <= 11) begin
        drv(R_PRE, b, a);
      end else if (r == 12) begin
        drv(R_REF, b, a);
      end else if (r == 13) begin
        drv(R_MRS, b, a);
      end else if (r == 14) begin
        cke = 1'b0;
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = rtab[$urandom_range(0, 5)];
        @(negedge ck);
        cke = 1'b1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
      end else begin
        drv(rtab[$urandom_range(0, 7)], b, a);
      end
      err_clr = 1'b0;
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
